// File: rtl/spmem_pkg.sv
// -----------------------------------------------------------------------------
// spmem_pkg
// Shared types for the sparse-memory port. The memory model and the bus
// monitor import this package as well as the initiator.
//   re_t        : read op types driven on mem_re_o
//   we_t        : write op types driven on mem_we_o
//   state_t     : initiator FSM states
//   spmem_cmd_t : one queued command {write, op, addr, wdata}
//   is_aligned  : natural-alignment rule for an op/address pair
// -----------------------------------------------------------------------------
package spmem_pkg;

    localparam int SPMEM_AW = 32;
    localparam int SPMEM_DW = 32;

    typedef enum logic [2:0] {
        RE_NONE = 3'd0,
        RE_B    = 3'd1,
        RE_H    = 3'd2,
        RE_W    = 3'd3,
        RE_BU   = 3'd4,
        RE_HU   = 3'd5
    } re_t;

    typedef enum logic [2:0] {
        WE_NONE = 3'd0,
        WE_B    = 3'd1,
        WE_H    = 3'd2,
        WE_W    = 3'd3
    } we_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CS   = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_RSP     = 3'd3,
        ST_WR      = 3'd4
    } state_t;

    typedef struct packed {
        logic                write;
        logic [2:0]          op;
        logic [SPMEM_AW-1:0] addr;
        logic [SPMEM_DW-1:0] wdata;
    } spmem_cmd_t;

    // Read and write encodings share the values for B/H/W, so one rule
    // covers both directions: halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_aligned(input logic [2:0] op,
                                        input logic [SPMEM_AW-1:0] addr);
        logic ok;
        ok = 1'b1;
        case (op)
            3'd2, 3'd5: ok = (addr[0] == 1'b0);
            3'd3:       ok = (addr[1:0] == 2'b00);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/spmem_initiator_cmd_fifo.sv
// -----------------------------------------------------------------------------
// spmem_cmd_fifo
// Synchronous in-order FIFO of spmem_cmd_t commands.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i/data_i: write one entry (ignored when full)
//   pop_i/data_o : data_o is the current head; pop_i discards it (ignored
//                  when empty)
//   full_o/empty_o: derived from the registered occupancy count
// -----------------------------------------------------------------------------
module spmem_cmd_fifo
    import spmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  spmem_cmd_t data_i,
    input  logic       pop_i,
    output spmem_cmd_t data_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    spmem_cmd_t    r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full_o    = (r_count == FULL_CNT);
    assign empty_o   = (r_count == '0);
    assign w_push_ok = push_i && !full_o;
    assign w_pop_ok  = pop_i && !empty_o;
    assign data_o    = r_mem[r_rptr];

    // Storage array: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= data_i;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tracks fill.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spmem_initiator.sv
// -----------------------------------------------------------------------------
// spmem_initiator
// Queues read/write commands and issues them one at a time, in order, to the
// sparse-memory port; read data returns on a valid/ready response channel.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   cmd_*                 : command channel (valid/ready)
//   rsp_*                 : read response channel (valid/ready), registered
//   wr_err_o              : one-cycle pulse when a misaligned write is dropped
//   mem_cs_no/re/raddr    : read strobe (chip-select active low), registered
//   mem_rdata_i           : read data, valid the cycle after mem_cs_no low
//   mem_we/waddr/wdata    : one-cycle write strobe, registered
// -----------------------------------------------------------------------------
module spmem_initiator
    import spmem_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic          cmd_write_i,
    input  logic [2:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_addr_i,
    input  logic [DW-1:0] cmd_wdata_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [DW-1:0] rsp_data_o,
    output logic          rsp_err_o,
    output logic          wr_err_o,
    output logic          mem_cs_no,
    output logic [2:0]    mem_re_o,
    output logic [AW-1:0] mem_raddr_o,
    input  logic [DW-1:0] mem_rdata_i,
    output logic [2:0]    mem_we_o,
    output logic [AW-1:0] mem_waddr_o,
    output logic [DW-1:0] mem_wdata_o
);

    spmem_cmd_t    w_cmd_in;
    spmem_cmd_t    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_can_issue;
    logic          w_pop;
    logic          w_head_ok;

    state_t        r_state;
    logic          r_mem_cs_n;
    logic [2:0]    r_mem_re;
    logic [AW-1:0] r_mem_raddr;
    logic [2:0]    r_mem_we;
    logic [AW-1:0] r_mem_waddr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic          r_rsp_err;
    logic          r_wr_err;

    assign w_cmd_in = '{write: cmd_write_i, op: cmd_op_i,
                        addr: cmd_addr_i, wdata: cmd_wdata_i};

    spmem_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (cmd_valid_i),
        .data_i  (w_cmd_in),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Ready comes from the registered count only; a same-cycle pop does not
    // reopen the slot until the next cycle.
    assign cmd_ready_o = !w_full;

    // The next command may be dispatched from IDLE, right after a write
    // strobe, or in the cycle a response is consumed.
    assign w_can_issue = (r_state == ST_IDLE) || (r_state == ST_WR) ||
                         ((r_state == ST_RSP) && rsp_ready_i);
    assign w_pop       = w_can_issue && !w_empty;
    assign w_head_ok   = is_aligned(w_head.op, w_head.addr);

    // Issue FSM with registered strobes; a pop overrides the per-state step.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_mem_cs_n  <= 1'b1;
            r_mem_re    <= RE_NONE;
            r_mem_raddr <= '0;
            r_mem_we    <= WE_NONE;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_mem_cs_n <= 1'b1;
            r_mem_re   <= RE_NONE;
            r_mem_we   <= WE_NONE;
            r_wr_err   <= 1'b0;
            case (r_state)
                ST_RD_CS: r_state <= ST_RD_DATA;
                ST_RD_DATA: begin
                    r_rsp_data  <= mem_rdata_i;
                    r_rsp_err   <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WR:   r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            if (w_pop) begin
                if (!w_head_ok) begin
                    if (w_head.write) begin
                        r_wr_err <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else begin
                        // Misaligned read never touches memory; answer at once.
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= '0;
                        r_state     <= ST_RSP;
                    end
                end else if (w_head.write) begin
                    r_mem_we    <= w_head.op;
                    r_mem_waddr <= w_head.addr;
                    r_mem_wdata <= w_head.wdata;
                    r_state     <= ST_WR;
                end else begin
                    r_mem_cs_n  <= 1'b0;
                    r_mem_re    <= w_head.op;
                    r_mem_raddr <= w_head.addr;
                    r_state     <= ST_RD_CS;
                end
            end
        end
    end

    assign mem_cs_no   = r_mem_cs_n;
    assign mem_re_o    = r_mem_re;
    assign mem_raddr_o = r_mem_raddr;
    assign mem_we_o    = r_mem_we;
    assign mem_waddr_o = r_mem_waddr;
    assign mem_wdata_o = r_mem_wdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign wr_err_o    = r_wr_err;

endmodule

// File: doc/spmem_initiator.md
# spmem_initiator

Synthesizable initiator for the sparse-memory port. It accepts read and write commands on a valid/ready command interface and buffers them in a small in-order FIFO. It drives the memory-side chip-select, op-type, address and data lines, one transaction at a time, and returns read data on a valid/ready response interface. It sits between a test sequencer or core load/store unit and the sparse memory, on the opposite end of the bus the monitor observes.

## Interface
- AW, 32, address width
- DW, 32, data width
- DEPTH, 4, command FIFO depth (power of two, ≥2)
- clk_i  in  1  clock, all logic rising-edge
- rst_i  in  1  reset; asynchronous, active-high
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO not full
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_op_i  in  3  op type; re_t when reading, we_t when writing
- cmd_addr_i  in  AW  byte address
- cmd_wdata_i  in  DW  write data, LSB-aligned
- rsp_valid_o  out  1  read response valid
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  DW  read data, passed through unchanged
- rsp_err_o  out  1  response belongs to a misaligned read
- wr_err_o  out  1  one-cycle pulse: misaligned write dropped
- mem_cs_no  out  1  active-low read chip-select
- mem_re_o  out  3  read op type (re_t)
- mem_raddr_o  out  AW  read address
- mem_rdata_i  in  DW  read data, valid the cycle after mem_cs_no is low
- mem_we_o  out  3  write op type (we_t), WE_NONE when idle
- mem_waddr_o, mem_wdata_o  out  AW, DW  write address/data

## Operation
- Command accepted when cmd_valid_i && cmd_ready_o, then pushed to FIFO. Strict in-order issue, single outstanding transaction.
- Alignment check at pop: H/HU need addr[0]=0; W needs addr[1:0]=0; B/BU are always aligned.
- FSM states: IDLE, RD_CS, RD_DATA, RSP, WR.
- IDLE, FIFO non-empty: pop the head.
  - Aligned read → RD_CS.
  - Aligned write → WR.
  - Misaligned read → RSP with rsp_err_o=1, rsp_data_o=0.
  - Misaligned write → stay IDLE, pulse wr_err_o.
- RD_CS: mem_cs_no=0, mem_re_o/mem_raddr_o held stable. Next state RD_DATA.
- RD_DATA: mem_cs_no=1; capture mem_rdata_i at end of cycle; → RSP.
- RSP: rsp_valid_o=1; data/err held stable until rsp_ready_i. On handshake, pop the next command if available (same dispatch as IDLE), else → IDLE.
- WR: mem_we_o=op, mem_waddr_o/mem_wdata_o valid for exactly one cycle. Then dispatch the next command as IDLE does, so back-to-back writes issue one per cycle.
- Outside RD_CS: mem_re_o=RE_NONE. Outside WR: mem_we_o=WE_NONE.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, but cmd_ready_o is computed from registered count (no combinational ready bypass).

## Timing
- All memory-side outputs and rsp_* are registered.
- Reset values:
  - mem_cs_no=1; mem_re_o=RE_NONE; mem_we_o=WE_NONE.
  - Addresses and data 0.
  - rsp_valid_o=0, rsp_err_o=0, wr_err_o=0.
  - cmd_ready_o=1 once reset is released.
  - FIFO empty; FSM IDLE.
- Read accepted in cycle N with the FSM idle and FIFO empty:
  - FIFO head visible N+1.
  - mem_cs_no low N+2.
  - mem_rdata_i sampled N+3.
  - rsp_valid_o high N+4.
- Write accepted in cycle N: mem_we_o active in N+2 only.
- wr_err_o pulses in the cycle after the misaligned pop.
- Reset asserted mid-transaction aborts at once: no further strobes, queued commands discarded, response lost.
- Pointer wrap-around is modulo DEPTH; count is $clog2(DEPTH)+1 bits.

## Structure
- spmem_pkg holds:
  - re_t {RE_NONE, RE_B, RE_H, RE_W, RE_BU, RE_HU}
  - we_t {WE_NONE, WE_B, WE_H, WE_W}
  - packed spmem_cmd_t {write, op, addr, wdata}
  - function is_aligned(op, addr)
- spmem_pkg is shared with the memory model and the monitor.
- Sub-module spmem_cmd_fifo: parametric synchronous FIFO of spmem_cmd_t with push/pop/full/empty and async active-high reset.

## Test plan
- Read W @0x100 with memory holding 0xDEADBEEF → mem_cs_no low 2 cycles after accept, rsp_valid_o 4 cycles after, rsp_data_o=0xDEADBEEF, rsp_err_o=0.
- Writes SW 0x10=0x11111111, SW 0x14=0x22222222, SB 0x18=0xAA issued back-to-back → mem_we_o W,W,B on three consecutive cycles with matching addr/data; then read W @0x14 returns 0x22222222.
- Push 5 commands with rsp_ready_i=0 and DEPTH=4 → cmd_ready_o=0 after the FIFO fills; first response held stable until rsp_ready_i, then the remainder drains in order.
- Read H @0x101 → no mem_cs_no strobe; rsp_err_o=1, rsp_data_o=0. Write W @0x102 → wr_err_o one-cycle pulse, mem_we_o stays WE_NONE.
- Assert rst_i during RD_DATA with 2 commands queued → all outputs return to reset values asynchronously; no memory strobes after release until new commands arrive.
